ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- EX/MEM pipeline register sitting directly downstream of the 16-bit ALU.
- Captures the ALU result, overflow, opcode and the control/destination fields travelling with the instruction.
- Owns the architectural flag register (Z, V, N), updating it from the ALU result according to opcode.
- Supports stall (hold) and flush (bubble insertion); one cycle latency from EX inputs to MEM-side outputs.

Parameters:
- DW, 16, datapath width of ALU result and store data
- RW, 4, register-specifier width

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  hold all stage state this cycle
- flush  input  1  replace incoming instruction with a bubble
- ex_valid  input  1  EX stage holds a real instruction
- ex_op  input  4  opcode of EX instruction (ALU encoding: ADD 0000, SUB 0001, RED 0010, XOR 0011, SLL 0100, SRA 0101, ROR 0110, PADDSB 0111, MEM 10xx, CTRL 11xx)
- alu_out  input  DW  ALU result (data result or memory address)
- alu_ovfl  input  1  ALU overflow
- ex_store_data  input  DW  register data for stores
- ex_rd  input  RW  destination register
- ex_regwrite  input  1  instruction writes a register
- ex_memread  input  1  load
- ex_memwrite  input  1  store
- mem_valid  output  1  MEM stage holds a real instruction
- mem_op  output  4  registered opcode
- mem_result  output  DW  registered alu_out (data address for MEM ops)
- mem_store_data  output  DW  registered store data
- mem_rd  output  RW  registered destination
- mem_regwrite  output  1  registered, qualified by valid
- mem_memread  output  1  registered, qualified by valid
- mem_memwrite  output  1  registered, qualified by valid
- flags  output  3  {Z, V, N} architectural flag register
- fwd_en  output  1  mem_valid & mem_regwrite & ~mem_memread (result forwardable to EX)

Behaviour:
- Reset (rst_n low, asynchronous): every output and internal register = 0, including flags = 3'b000. Takes effect immediately, independent of clk; a reset mid-stall or mid-flush discards all state.
- Capture condition: load = ~stall. Priority is stall > flush > normal.
- stall=1: all registers hold, flags hold, flush ignored (the upstream source must keep flush asserted until stall drops).
- stall=0, flush=1: bubble loaded: mem_valid=0, mem_regwrite/memread/memwrite=0, mem_op/result/store_data/rd = 0. Flags do not update.
- stall=0, flush=0: all mem_* fields load their ex_* counterparts.
- mem_valid = ex_valid. mem_regwrite/memread/memwrite = ex_* & ex_valid, so an invalid EX slot never produces side effects.
- Flag update (only when stall=0, flush=0, ex_valid=1):
  - Z_new = (alu_out == 0), N_new = alu_out[DW-1], V_new = alu_ovfl.
  - ADD, SUB: Z, V, N all update.
  - XOR, SLL, SRA, ROR: Z updates; V, N hold.
  - RED, PADDSB, MEM, CTRL: all flags hold.
- Flags are registered: the new value is visible the cycle after the instruction leaves EX. Branch logic reading flags in the following cycle sees the update with no bypass required.
- fwd_en is combinational from registered state; no path from ex_* inputs to any output.
- Back-to-back updates: each cycle's qualifying instruction overwrites the flags it owns; no accumulation.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle after loading state -> all outputs 0 immediately, flags=000; release and idle -> mem_valid stays 0.
- ADD flags: ex_valid=1, op=0000, alu_out=16'h0000, alu_ovfl=1 -> next cycle flags=Z1 V1 N0, mem_result=0000, mem_valid=1.
- Partial update: after the ADD above, XOR with alu_out=16'h8001, ovfl=0 -> flags=Z0 V1 N0 (V, N held); then PADDSB alu_out=0 -> flags unchanged.
- Stall/flush priority: load LW (op=1000, memread=1, alu_out=16'h0040, rd=3); then stall=1 & flush=1 for 2 cycles with new inputs -> outputs frozen at LW values, fwd_en=0; stall=0, flush=1 -> bubble, all controls 0, flags unchanged.
- Invalid slot: ex_valid=0, op=0001, ex_regwrite=1, memwrite=1, alu_out=0 -> mem_valid=0, mem_regwrite=0, mem_memwrite=0, flags unchanged.
- Forward enable: SUB rd=5, regwrite=1, alu_out=16'hFFFE -> fwd_en=1, mem_rd=5, flags N=1 Z=0; following load to rd=5 -> fwd_en=0.

Source files
------------

// File: rtl/ex_mem_stage_if.sv
// EX -> MEM stage bus: EX-side instruction fields in, registered MEM-side fields and flags out.
// stall/flush travel with the bus because they come from the same hazard unit that feeds EX.
interface ex_mem_stage_if #(
  parameter int DW = 16,
  parameter int RW = 4
);
  logic          stall;
  logic          flush;
  logic          ex_valid;
  logic [3:0]    ex_op;
  logic [DW-1:0] alu_out;
  logic          alu_ovfl;
  logic [DW-1:0] ex_store_data;
  logic [RW-1:0] ex_rd;
  logic          ex_regwrite;
  logic          ex_memread;
  logic          ex_memwrite;

  logic          mem_valid;
  logic [3:0]    mem_op;
  logic [DW-1:0] mem_result;
  logic [DW-1:0] mem_store_data;
  logic [RW-1:0] mem_rd;
  logic          mem_regwrite;
  logic          mem_memread;
  logic          mem_memwrite;
  logic [2:0]    flags;
  logic          fwd_en;

  modport master (
    output stall, flush, ex_valid, ex_op, alu_out, alu_ovfl, ex_store_data,
           ex_rd, ex_regwrite, ex_memread, ex_memwrite,
    input  mem_valid, mem_op, mem_result, mem_store_data, mem_rd,
           mem_regwrite, mem_memread, mem_memwrite, flags, fwd_en
  );

  modport slave (
    input  stall, flush, ex_valid, ex_op, alu_out, alu_ovfl, ex_store_data,
           ex_rd, ex_regwrite, ex_memread, ex_memwrite,
    output mem_valid, mem_op, mem_result, mem_store_data, mem_rd,
           mem_regwrite, mem_memread, mem_memwrite, flags, fwd_en
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register plus {Z,V,N} flag register; one cycle EX->MEM latency.
// Backpressure: stall holds everything (and overrides flush); flush loads a bubble.
module ex_mem_stage #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input logic           clk,
  input logic           rst_n,
  ex_mem_stage_if.slave bus
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;

  logic          valid_q;
  logic [3:0]    op_q;
  logic [DW-1:0] result_q;
  logic [DW-1:0] store_data_q;
  logic [RW-1:0] rd_q;
  logic          regwrite_q;
  logic          memread_q;
  logic          memwrite_q;
  logic          flag_z_q;
  logic          flag_v_q;
  logic          flag_n_q;

  logic z_new;
  assign z_new = (bus.alu_out == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      op_q         <= '0;
      result_q     <= '0;
      store_data_q <= '0;
      rd_q         <= '0;
      regwrite_q   <= 1'b0;
      memread_q    <= 1'b0;
      memwrite_q   <= 1'b0;
      flag_z_q     <= 1'b0;
      flag_v_q     <= 1'b0;
      flag_n_q     <= 1'b0;
    end else if (!bus.stall) begin
      if (bus.flush) begin
        valid_q      <= 1'b0;
        op_q         <= '0;
        result_q     <= '0;
        store_data_q <= '0;
        rd_q         <= '0;
        regwrite_q   <= 1'b0;
        memread_q    <= 1'b0;
        memwrite_q   <= 1'b0;
      end else begin
        valid_q      <= bus.ex_valid;
        op_q         <= bus.ex_op;
        result_q     <= bus.alu_out;
        store_data_q <= bus.ex_store_data;
        rd_q         <= bus.ex_rd;
        // Side-effect controls are masked so an empty EX slot can never write.
        regwrite_q   <= bus.ex_regwrite & bus.ex_valid;
        memread_q    <= bus.ex_memread & bus.ex_valid;
        memwrite_q   <= bus.ex_memwrite & bus.ex_valid;
        if (bus.ex_valid) begin
          case (bus.ex_op)
            OP_ADD, OP_SUB: begin
              flag_z_q <= z_new;
              flag_v_q <= bus.alu_ovfl;
              flag_n_q <= bus.alu_out[DW-1];
            end
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: flag_z_q <= z_new;
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.mem_valid      = valid_q;
  assign bus.mem_op         = op_q;
  assign bus.mem_result     = result_q;
  assign bus.mem_store_data = store_data_q;
  assign bus.mem_rd         = rd_q;
  assign bus.mem_regwrite   = regwrite_q;
  assign bus.mem_memread    = memread_q;
  assign bus.mem_memwrite   = memwrite_q;
  assign bus.flags          = {flag_z_q, flag_v_q, flag_n_q};
  assign bus.fwd_en         = valid_q & regwrite_q & ~memread_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed sequences plus a random phase, scoreboarded.
module tb_ex_mem_stage;

  logic clk = 1'b0;
  logic rst_n;

  ex_mem_stage_if #(.DW(16), .RW(4)) bus ();

  ex_mem_stage #(.DW(16), .RW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [15:0] result;
    logic [15:0] sdata;
    logic [3:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [2:0]  flags;
    logic        fwd;
  } exp_t;

  exp_t m;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare(input string tag, input exp_t e);
    check({tag, ".valid"}, 32'(bus.mem_valid), 32'(e.valid));
    check({tag, ".op"}, 32'(bus.mem_op), 32'(e.op));
    check({tag, ".result"}, 32'(bus.mem_result), 32'(e.result));
    check({tag, ".sdata"}, 32'(bus.mem_store_data), 32'(e.sdata));
    check({tag, ".rd"}, 32'(bus.mem_rd), 32'(e.rd));
    check({tag, ".regwrite"}, 32'(bus.mem_regwrite), 32'(e.rw));
    check({tag, ".memread"}, 32'(bus.mem_memread), 32'(e.mr));
    check({tag, ".memwrite"}, 32'(bus.mem_memwrite), 32'(e.mw));
    check({tag, ".flags"}, 32'(bus.flags), 32'(e.flags));
    check({tag, ".fwd_en"}, 32'(bus.fwd_en), 32'(e.fwd));
  endtask

  // Reference behaviour of one clock edge given the currently driven inputs.
  function automatic exp_t predict(input exp_t c);
    exp_t n;
    logic z;
    n = c;
    z = (bus.alu_out == 16'h0000);
    if (!bus.stall) begin
      if (bus.flush) begin
        n.valid = 0; n.op = 0; n.result = 0; n.sdata = 0; n.rd = 0;
        n.rw = 0; n.mr = 0; n.mw = 0;
      end else begin
        n.valid  = bus.ex_valid;
        n.op     = bus.ex_op;
        n.result = bus.alu_out;
        n.sdata  = bus.ex_store_data;
        n.rd     = bus.ex_rd;
        n.rw     = bus.ex_valid ? bus.ex_regwrite : 1'b0;
        n.mr     = bus.ex_valid ? bus.ex_memread : 1'b0;
        n.mw     = bus.ex_valid ? bus.ex_memwrite : 1'b0;
        if (bus.ex_valid) begin
          if (bus.ex_op == 4'd0 || bus.ex_op == 4'd1)
            n.flags = {z, bus.alu_ovfl, bus.alu_out[15]};
          else if (bus.ex_op >= 4'd3 && bus.ex_op <= 4'd6)
            n.flags[2] = z;
        end
      end
    end
    n.fwd = n.valid && n.rw && !n.mr;
    return n;
  endfunction

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] alu,
                       input logic ov, input logic [15:0] sd, input logic [3:0] rd,
                       input logic rw, input logic mr, input logic mw);
    bus.ex_valid = v; bus.ex_op = op; bus.alu_out = alu; bus.alu_ovfl = ov;
    bus.ex_store_data = sd; bus.ex_rd = rd; bus.ex_regwrite = rw;
    bus.ex_memread = mr; bus.ex_memwrite = mw;
  endtask

  task automatic step(input string tag);
    exp_t e;
    m = predict(m);
    sb.push_back(m);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      compare(tag, e);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.stall = 0; bus.flush = 0;
    drive(0, 4'h0, 16'h0, 0, 16'h0, 4'h0, 0, 0, 0);
    m = '0;
    #12;
    compare("reset", m);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD: zero result with overflow
    drive(1, 4'b0000, 16'h0000, 1, 16'h1234, 4'h1, 1, 0, 0);
    step("add");
    check("add_flags_zvn", 32'(bus.flags), 32'b110);
    // XOR: only Z moves
    drive(1, 4'b0011, 16'h8001, 0, 16'h0, 4'h2, 1, 0, 0);
    step("xor");
    check("xor_flags", 32'(bus.flags), 32'b010);
    // PADDSB: flags untouched
    drive(1, 4'b0111, 16'h0000, 1, 16'h0, 4'h2, 1, 0, 0);
    step("paddsb");
    check("paddsb_flags", 32'(bus.flags), 32'b010);

    // LW, then stall+flush with changing inputs, then flush alone
    drive(1, 4'b1000, 16'h0040, 0, 16'h0, 4'h3, 1, 1, 0);
    step("lw");
    check("lw_fwd", 32'(bus.fwd_en), 32'd0);
    bus.stall = 1; bus.flush = 1;
    drive(1, 4'b0000, 16'h7777, 1, 16'h5555, 4'h9, 1, 0, 1);
    step("stall1");
    drive(1, 4'b0001, 16'hFFFF, 0, 16'hAAAA, 4'hA, 1, 0, 0);
    step("stall2");
    check("stall_hold_result", 32'(bus.mem_result), 32'h0040);
    bus.stall = 0;
    step("flush");
    check("flush_valid", 32'(bus.mem_valid), 32'd0);
    check("flush_flags", 32'(bus.flags), 32'b010);
    bus.flush = 0;

    // Invalid slot must not produce side effects or move flags
    drive(0, 4'b0001, 16'h0000, 1, 16'h0, 4'h4, 1, 0, 1);
    step("invalid");
    check("invalid_memwrite", 32'(bus.mem_memwrite), 32'd0);

    // SUB forwardable, then load to same rd is not
    drive(1, 4'b0001, 16'hFFFE, 0, 16'h0, 4'h5, 1, 0, 0);
    step("sub");
    check("sub_fwd", 32'(bus.fwd_en), 32'd1);
    check("sub_flags", 32'(bus.flags), 32'b001);
    drive(1, 4'b1000, 16'h0010, 0, 16'h0, 4'h5, 1, 1, 0);
    step("ld_rd5");
    check("ld_fwd", 32'(bus.fwd_en), 32'd0);

    // Random mix of ops, stalls and flushes
    for (int i = 0; i < 60; i++) begin
      bus.stall = ($urandom_range(0, 4) == 0);
      bus.flush = ($urandom_range(0, 5) == 0);
      drive(1'($urandom_range(0, 1) | $urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom),
            1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step("rand");
    end
    bus.stall = 0; bus.flush = 0;

    // Load known state, then reset asynchronously mid-cycle
    drive(1, 4'b0001, 16'h8000, 1, 16'hBEEF, 4'h7, 1, 0, 1);
    step("pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    m = '0;
    compare("async_reset", m);
    #2;
    rst_n = 1'b1;
    drive(0, 4'h0, 16'h0, 0, 16'h0, 4'h0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
